// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce filter.
package debounce_pkg;

    localparam int SYNC_STAGES = 2;

    function automatic int cnt_width(input int max);
        return $clog2(max);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/debounce_filter.sv
// Debounces a noisy level: the synchronized input must differ from clean_out
// for COUNTER_MAX consecutive cycles before clean_out follows it.
// Optional rise/fall edge pulses when DEBOUNCE_PULSE_EN is defined.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int COUNTER_MAX = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_in,
`ifdef DEBOUNCE_PULSE_EN
    output logic rise_pulse,
    output logic fall_pulse,
`endif
    output logic clean_out
);

    localparam int CNT_W = cnt_width(COUNTER_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER_MAX - 1);

    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (noisy_in),
        .q   (sync_q)
    );

    // Any sample matching the current clean level restarts the full window.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (sync_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = sync_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_out = clean_q;

`ifdef DEBOUNCE_PULSE_EN
    logic clean_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_dly_q <= 1'b0;
        end else begin
            clean_dly_q <= clean_q;
        end
    end

    assign rise_pulse = clean_q & ~clean_dly_q;
    assign fall_pulse = ~clean_q & clean_dly_q;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter with COUNTER_MAX = 128.
module tb_debounce_filter;

    localparam int CMAX = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic noisy_in = 1'b1;
    logic clean_out;
`ifdef DEBOUNCE_PULSE_EN
    logic rise_pulse;
    logic fall_pulse;
    int   n_rise = 0;
    int   n_fall = 0;
    int   n_long = 0;
    logic rise_prev = 1'b0;
    logic fall_prev = 1'b0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #10 clk = ~clk;

    debounce_filter #(.COUNTER_MAX(CMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .noisy_in  (noisy_in),
`ifdef DEBOUNCE_PULSE_EN
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
`endif
        .clean_out (clean_out)
    );

`ifdef DEBOUNCE_PULSE_EN
    always @(negedge clk) begin
        if (rise_pulse) n_rise++;
        if (fall_pulse) n_fall++;
        if ((rise_pulse && rise_prev) || (fall_pulse && fall_prev)) n_long++;
        rise_prev = rise_pulse;
        fall_prev = fall_pulse;
    end
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v);
        @(negedge clk);
        noisy_in = v;
    endtask

    // Hold a level for n cycles while checking clean_out never changes.
    task automatic hold_chk(input string tag, input logic v, input int n, input logic exp);
        set_in(v);
        for (int i = 0; i < n; i++) begin
            step(1);
            if (clean_out !== exp) begin
                chk(tag, int'(clean_out), int'(exp));
                return;
            end
        end
        chk(tag, int'(clean_out), int'(exp));
    endtask

    initial begin
        #20;
        chk("rst_clean", int'(clean_out), 0);
        chk("rst_cnt", int'(dut.cnt_q), 0);
        #20;
        chk("rst_clean_late", int'(clean_out), 0);
        #10 rst = 1'b0;

        // Bounce rejection: all high runs shorter than the window
        hold_chk("bounce_h1", 1'b1, 10, 1'b0);
        hold_chk("bounce_l1", 1'b0, 3, 1'b0);
        hold_chk("bounce_h2", 1'b1, 8, 1'b0);
        hold_chk("bounce_l2", 1'b0, 10, 1'b0);

        // Stable press: change lands on the 130th edge
        set_in(1'b1);
        step(CMAX + 1);
        chk("press_early", int'(clean_out), 0);
        step(1);
        chk("press_exact", int'(clean_out), 1);
        hold_chk("press_hold", 1'b1, 250, 1'b1);

        // Release bounce: short lows must not move clean_out
        hold_chk("rel_g1", 1'b0, 3, 1'b1);
        hold_chk("rel_h1", 1'b1, 5, 1'b1);
        chk("rel_cnt_clr1", int'(dut.cnt_q), 0);
        hold_chk("rel_g2", 1'b0, 3, 1'b1);
        hold_chk("rel_h2", 1'b1, 5, 1'b1);
        chk("rel_cnt_clr2", int'(dut.cnt_q), 0);

        // Stable release
        set_in(1'b0);
        step(CMAX + 1);
        chk("release_early", int'(clean_out), 1);
        step(1);
        chk("release_exact", int'(clean_out), 0);
        step(20);

        // 127 high cycles: one short of the window
        set_in(1'b1);
        step(CMAX - 1);
        set_in(1'b0);
        step(5);
        chk("bnd127_cnt_clr", int'(dut.cnt_q), 0);
        step(140);
        chk("bnd127", int'(clean_out), 0);

        // 128+2 high cycles: just enough
        set_in(1'b1);
        step(CMAX + 2);
        chk("bnd130", int'(clean_out), 1);
        set_in(1'b0);
        step(CMAX + 1);
        chk("bnd130_rel_early", int'(clean_out), 1);
        step(1);
        chk("bnd130_rel", int'(clean_out), 0);
        step(20);

        // Reset mid-count
        set_in(1'b1);
        step(100);
        chk("mid_cnt", int'(dut.cnt_q), 98);
        #5 rst = 1'b1;
        #1;
        chk("mid_rst_cnt", int'(dut.cnt_q), 0);
        chk("mid_rst_clean", int'(clean_out), 0);
        step(2);
        @(negedge clk);
        rst = 1'b0;
        step(CMAX + 1);
        chk("restart_early", int'(clean_out), 0);
        step(1);
        chk("restart_exact", int'(clean_out), 1);

        set_in(1'b0);
        step(CMAX + 3);
        chk("final_low", int'(clean_out), 0);

`ifdef DEBOUNCE_PULSE_EN
        step(2);
        chk("n_rise", n_rise, 3);
        chk("n_fall", n_fall, 3);
        chk("pulse_width", n_long, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
